// File: rtl/muldiv_unit_if.sv
// Request / write-back bundle between the core and the iterative multiply/divide unit.
// Handshake: a request is taken on a rising edge where start=1, flush=0 and busy=0;
// busy then stays high through the one-cycle done/wb_en pulse, and start is ignored meanwhile.
interface muldiv_unit_if #(
  parameter int XLEN       = 32,
  parameter int REG_ADDR_W = 5
);
  logic                  start;
  logic                  flush;
  logic [1:0]            op;
  logic [XLEN-1:0]       operand_a;
  logic [XLEN-1:0]       operand_b;
  logic [REG_ADDR_W-1:0] dest_reg;
  logic                  busy;
  logic                  done;
  logic                  wb_en;
  logic [REG_ADDR_W-1:0] wb_reg;
  logic [XLEN-1:0]       wb_data;
  logic [1:0]            fsm_state;

  modport master (
    output start, flush, op, operand_a, operand_b, dest_reg,
    input  busy, done, wb_en, wb_reg, wb_data, fsm_state
  );

  modport slave (
    input  start, flush, op, operand_a, operand_b, dest_reg,
    output busy, done, wb_en, wb_reg, wb_data, fsm_state
  );
endinterface

// File: rtl/muldiv_unit.sv
// Iterative unsigned multiply (shift-add) / divide (restoring) unit, one bit per cycle,
// writing its single result back through a register-file write port.
module muldiv_unit #(
  parameter int XLEN       = 32,
  parameter int REG_ADDR_W = 5
) (
  input  logic          clock,
  input  logic          rst,
  muldiv_unit_if.slave  bus
);
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DIV  = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam int CNT_W = $clog2(XLEN);

  state_t                state;
  state_t                state_nxt;
  logic [CNT_W-1:0]      count;
  logic [1:0]            op_q;
  logic [REG_ADDR_W-1:0] dest_q;
  logic [XLEN-1:0]       opnd_q;
  logic [2*XLEN-1:0]     acc;
  logic [XLEN-1:0]       rem;

  logic                  accept;
  logic                  div_zero;
  logic                  last_step;
  logic [XLEN:0]         mul_sum;
  logic [XLEN:0]         div_part;
  logic [XLEN:0]         div_diff;

  assign accept    = (state == IDLE) && bus.start && !bus.flush;
  assign div_zero  = bus.op[1] && (bus.operand_b == '0);
  assign last_step = (count == CNT_W'(XLEN - 1));

  // Multiply: acc = {partial high, remaining multiplier bits}; divide: acc low half
  // shifts dividend bits out the top and quotient bits in at the bottom.
  assign mul_sum  = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, opnd_q} : '0);
  assign div_part = {rem, acc[XLEN-1]};
  assign div_diff = div_part - {1'b0, opnd_q};

  always_ff @(posedge clock or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (bus.flush) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE:     if (bus.start) state_nxt = div_zero ? DONE : (bus.op[1] ? DIV : MUL);
        MUL, DIV: if (last_step) state_nxt = DONE;
        DONE:     state_nxt = IDLE;
        default:  state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clock or negedge rst) begin
    if (!rst) begin
      count  <= '0;
      op_q   <= '0;
      dest_q <= '0;
      opnd_q <= '0;
      acc    <= '0;
      rem    <= '0;
    end else if (bus.flush) begin
      count <= '0;
    end else if (accept) begin
      count  <= '0;
      op_q   <= bus.op;
      dest_q <= bus.dest_reg;
      opnd_q <= bus.op[1] ? bus.operand_b : bus.operand_a;
      if (!bus.op[1]) begin
        acc <= {{XLEN{1'b0}}, bus.operand_b};
        rem <= '0;
      end else if (div_zero) begin
        // Preload the divide-by-zero results so DONE reads them like any other.
        acc <= {{XLEN{1'b0}}, {XLEN{1'b1}}};
        rem <= bus.operand_a;
      end else begin
        acc <= {{XLEN{1'b0}}, bus.operand_a};
        rem <= '0;
      end
    end else if (state == MUL) begin
      acc   <= {mul_sum, acc[XLEN-1:1]};
      count <= count + CNT_W'(1);
    end else if (state == DIV) begin
      rem            <= div_diff[XLEN] ? div_part[XLEN-1:0] : div_diff[XLEN-1:0];
      acc[XLEN-1:0]  <= {acc[XLEN-2:0], ~div_diff[XLEN]};
      count          <= count + CNT_W'(1);
    end
  end

  always_comb begin
    bus.busy    = (state != IDLE);
    bus.done    = (state == DONE);
    bus.wb_en   = 1'b0;
    bus.wb_reg  = '0;
    bus.wb_data = '0;
    if (state == DONE) begin
      bus.wb_en  = (dest_q != '0) && !bus.flush;
      bus.wb_reg = dest_q;
      case (op_q)
        2'b00:   bus.wb_data = acc[XLEN-1:0];
        2'b01:   bus.wb_data = acc[2*XLEN-1:XLEN];
        2'b10:   bus.wb_data = acc[XLEN-1:0];
        default: bus.wb_data = rem;
      endcase
    end
  end

  assign bus.fsm_state = state;
endmodule
